// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t     : controller states (IDLE, CALC, DONE)
//   digit_t     : recoded Booth digit values
//   nstep()     : radix-4 iteration count for a given operand width
//   booth_digit(): 3-bit window {q1,q0,q_minus1} -> Booth digit
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Operands are extended by two bits so unsigned values stay positive;
    // each iteration retires two bits of that extended multiplier.
    function automatic int unsigned nstep(input int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic digit_t booth_digit(input logic [2:0] window);
        digit_t d;
        case (window)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth partial-product generator (combinational).
// Ports:
//   window : {Q[1], Q[0], Q[-1]} multiplier window
//   m      : multiplicand, already extended to WIDTH+2 bits
//   addend : d*m as a WIDTH+3 bit two's-complement value, d in {0,+-1,+-2}
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+2:0] addend
);

    digit_t           digit;
    logic [WIDTH+2:0] m_x1;
    logic [WIDTH+2:0] m_x2;

    assign digit = booth_digit(window);
    assign m_x1  = {m[WIDTH+1], m};
    assign m_x2  = {m, 1'b0};

    always_comb begin
        addend = '0;
        case (digit)
            POS1:    addend = m_x1;
            POS2:    addend = m_x2;
            NEG1:    addend = -m_x1;
            NEG2:    addend = -m_x2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes and
// per-operation signed/unsigned mode. Retires two multiplier bits per cycle.
// Ports:
//   CLK, RESET        : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready : operand handshake; X, Y, signed_mode sampled on accept
//   X, Y              : multiplicand / multiplier (WIDTH bits)
//   signed_mode       : 1 = two's-complement operands, 0 = unsigned
//   out_valid/out_ready: result handshake; Z held stable until accepted
//   Z                 : 2*WIDTH bit product, keeps last value until next product
//   busy              : operation in progress
module booth_radix4_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 busy
);

    localparam int unsigned NSTEP = nstep(WIDTH);
    localparam int unsigned XW    = WIDTH + 2;
    localparam int unsigned AW    = WIDTH + 3;
    localparam int unsigned CNT_W = $clog2(NSTEP);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic [XW-1:0]    m_reg;
    logic [XW-1:0]    q_reg;
    logic             q_m1;
    logic [AW-1:0]    acc;

    logic [XW-1:0]    x_ext;
    logic [XW-1:0]    y_ext;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    acc_sum;
    logic [AW-1:0]    acc_next;
    logic [XW-1:0]    q_next;
    logic [2*WIDTH-1:0] z_next;
    logic             accept;

    assign x_ext = signed_mode ? {{2{X[WIDTH-1]}}, X} : {2'b00, X};
    assign y_ext = signed_mode ? {{2{Y[WIDTH-1]}}, Y} : {2'b00, Y};

    booth_r4_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .window (({q_reg[1:0], q_m1})),
        .m      (m_reg),
        .addend (addend)
    );

    // Add the partial product, then arithmetic-shift {acc, Q, Q[-1]} right by 2.
    assign acc_sum  = acc + addend;
    assign acc_next = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
    assign q_next   = {acc_sum[1:0], q_reg[XW-1:2]};
    // After the final shift {acc, Q} is the extended product; keep its low 2*WIDTH bits.
    assign z_next   = {acc_next[WIDTH-3:0], q_next};

    assign accept = in_valid && (state == IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            m_reg <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            acc   <= '0;
            Z     <= '0;
        end else if (accept) begin
            cnt   <= CNT_W'(NSTEP - 1);
            m_reg <= x_ext;
            q_reg <= y_ext;
            q_m1  <= 1'b0;
            acc   <= '0;
        end else if (state == CALC) begin
            cnt   <= cnt - 1'b1;
            acc   <= acc_next;
            q_reg <= q_next;
            q_m1  <= q_reg[1];
            if (cnt == '0) Z <= z_next;
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Scoreboard bench for booth_radix4_seq_mult: a 32-bit instance for directed
// and random operations, and an 8-bit instance for a random/corner sweep.
module tb_booth_radix4_seq_mult;

    logic        CLK = 1'b0;
    logic        RESET;

    logic        in_valid, in_ready, signed_mode, out_valid, busy;
    logic        out_ready = 1'b1;
    logic [31:0] X, Y;
    logic [63:0] Z;

    logic        b_in_valid, b_in_ready, b_signed_mode, b_out_valid, b_busy;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_x, b_y;
    logic [15:0] b_z;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [15:0] exp_q8[$];

    int unsigned cyc        = 0;
    int unsigned accept_cyc = 0;
    logic        prev_ov    = 1'b0;
    bit          rand_rdy   = 1'b0;
    logic        forced_rdy = 1'b1;

    always #5 CLK = ~CLK;

    booth_radix4_seq_mult #(.WIDTH(32)) u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .X           (X),
        .Y           (Y),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Z           (Z),
        .busy        (busy)
    );

    booth_radix4_seq_mult #(.WIDTH(8)) u_dut8 (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .X           (b_x),
        .Y           (b_y),
        .signed_mode (b_signed_mode),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .Z           (b_z),
        .busy        (b_busy)
    );

    // Reference: plain integer multiplication of the operands as interpreted by the mode.
    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return 64'(longint'(signed'(a)) * longint'(signed'(b)));
        return 64'(longint'(a) * longint'(b));
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) return 16'(int'(signed'(a)) * int'(signed'(b)));
        return 16'(int'(a) * int'(b));
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h7F;
            3:       return 8'h80;
            4:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out, expected DUT response", name);
    endtask

    // Result monitors: pop the oldest expected product on every output handshake.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL product32: got %h, expected no result", Z);
            end else begin
                check("product32", Z, exp_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET === 1'b1 && b_out_valid && b_out_ready) begin
            if (exp_q8.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL product8: got %h, expected no result", b_z);
            end else begin
                check("product8", 64'(b_z), 64'(exp_q8.pop_front()));
            end
        end
    end

    // Latency monitor for the 32-bit instance: out_valid must rise 17 cycles after accept.
    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (RESET !== 1'b1) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) accept_cyc = cyc + 1;
            if (out_valid && !prev_ov) check("latency32", 64'(cyc - accept_cyc), 64'd17);
            prev_ov = out_valid;
        end
    end

    // Output-ready drivers.
    initial forever begin
        @(posedge CLK);
        #1;
        out_ready   = rand_rdy ? 1'($urandom_range(0, 1)) : forced_rdy;
        b_out_ready = 1'($urandom_range(0, 3) != 0);
    end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] expected);
        int unsigned n = 0;
        X = a; Y = b; signed_mode = s; in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("accept32");
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        exp_q.push_back(expected);
        #1;
        in_valid = 1'b0;
        X = $urandom; Y = $urandom; signed_mode = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int unsigned n = 0;
        b_x = a; b_y = b; b_signed_mode = s; b_in_valid = 1'b1;
        @(negedge CLK);
        while (!b_in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!b_in_ready) begin
            timeout_fail("accept8");
            b_in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        exp_q8.push_back(ref8(a, b, s));
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain32();
        int unsigned n = 0;
        @(negedge CLK);
        while (!(exp_q.size() == 0 && in_ready) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) timeout_fail("drain32");
        @(posedge CLK);
        #1;
    endtask

    task automatic drain8();
        int unsigned n = 0;
        @(negedge CLK);
        while (!(exp_q8.size() == 0 && b_in_ready) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q8.size() != 0 || !b_in_ready) timeout_fail("drain8");
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int unsigned n;

        RESET = 1'b0;
        in_valid = 1'b0; X = '0; Y = '0; signed_mode = 1'b0;
        b_in_valid = 1'b0; b_x = '0; b_y = '0; b_signed_mode = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        check("reset_z",         Z,              64'd0);
        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Directed products from known values.
        issue32(32'd15,         32'hFFFF_FFE1, 1'b1, 64'hFFFF_FFFF_FFFF_FE2F);
        issue32(32'hFFFF_FFFF,  32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE);
        issue32(32'hFFFF_FFFF,  32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        issue32(32'h8000_0000,  32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        issue32(32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        issue32(32'h8000_0000,  32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
        drain32();

        // Backpressure: result must hold while out_ready is low.
        forced_rdy = 1'b0;
        @(posedge CLK);
        #1;
        issue32(32'd12345, 32'd6789, 1'b0, 64'd83810205);
        n = 0;
        @(negedge CLK);
        while (!out_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!out_valid) timeout_fail("bp_out_valid");
        repeat (5) begin
            @(negedge CLK);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_z",         Z,              64'd83810205);
        end
        forced_rdy = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        drain32();

        // New operands offered mid-operation are ignored.
        issue32(32'd1000, 32'd3000, 1'b0, 64'd3000000);
        in_valid = 1'b1; X = 32'd7; Y = 32'd9; signed_mode = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        in_valid = 1'b0;
        drain32();

        // Reset in the middle of a calculation.
        issue32(32'd55, 32'd66, 1'b0, 64'd3630);
        repeat (7) @(posedge CLK);
        #1;
        check("busy_mid_op", 64'(busy), 64'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("midreset_in_ready",  64'(in_ready),  64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_busy",      64'(busy),      64'd0);
        check("midreset_z",         Z,              64'd0);
        exp_q.delete();
        exp_q8.delete();
        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK);
        #1;
        issue32(32'hFFFF_CFCC, 32'hFFFF_2BCF, 1'b1, 64'd670321140);
        drain32();

        // Random 32-bit operations with random output backpressure.
        rand_rdy = 1'b1;
        repeat (150) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            issue32(a, b, s, ref32(a, b, s));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end
        drain32();
        rand_rdy = 1'b0;

        // 8-bit instance: corner-weighted random operands in both modes.
        repeat (800) issue8(pick8(), pick8(), 1'($urandom));
        drain8();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
